pipeline_mem_access: RTL

// MEM stage of the 5-stage pipeline: registers the EX-stage bundle and issues loads/stores to D-memory over a req/ready + rvalid handshake.

---
 rtl/pipeline_mem_access.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_mem_access.sv
// MEM stage: registers the EX bundle, runs loads/stores on D-memory, aligns store lanes and extends load data.
// Latency: non-memory ops 1 cycle EX->WB; memory ops 1 (IDLE) + grant wait + rvalid wait + 1 (DONE).
// Backpressure: stall_m_o holds EX while an aligned memory op is in flight; released for the single DONE cycle.
module pipeline_mem_access #(
    parameter int DMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_e_i,
    input  logic [31:0] alu_result_e_i,
    input  logic [31:0] store_data_e_i,
    input  logic [2:0]  mem_op_e_i,
    input  logic        mem_read_e_i,
    input  logic        mem_write_e_i,
    input  logic [31:0] extended_imm_e_i,
    input  logic [31:0] pc_plus4_e_i,
    input  logic [31:0] CSR_data_e_i,
    input  logic        reg_write_en_e_i,
    input  logic [4:0]  rd_idx_e_i,
    input  logic [4:0]  result_src_e_i,
    output logic        stall_m_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wstrb_o,
    input  logic        dmem_ready_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] alu_result_m_o,
    output logic [31:0] extended_imm_m_o,
    output logic [31:0] pc_plus4_m_o,
    output logic [31:0] CSR_data_m_o,
    output logic [31:0] mem_read_data_m_o,
    output logic        reg_write_en_m_o,
    output logic [4:0]  rd_idx_m_o,
    output logic [4:0]  result_src_m_o,
    output logic        misalign_m_o,
    output logic        bus_err_m_o
);
    localparam int CNT_W = $clog2(DMEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;

    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_store_data;
    logic [2:0]  m_op;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_imm;
    logic [31:0] m_pc4;
    logic [31:0] m_csr;
    logic        m_rwe;
    logic [4:0]  m_rd_idx;
    logic [4:0]  m_src;
    logic        m_bus_err;
    logic [31:0] m_load_data;

    logic        is_mem;
    logic        bad_op;
    logic        bad_align;
    logic        misalign;
    logic        mem_go;
    logic        tmo_last;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // Pipeline register: frozen while a memory op is outstanding
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid      <= 1'b0;
            m_addr       <= '0;
            m_store_data <= '0;
            m_op         <= '0;
            m_rd         <= 1'b0;
            m_wr         <= 1'b0;
            m_imm        <= '0;
            m_pc4        <= '0;
            m_csr        <= '0;
            m_rwe        <= 1'b0;
            m_rd_idx     <= '0;
            m_src        <= '0;
        end else if (!stall_m_o) begin
            m_valid      <= valid_e_i;
            m_addr       <= alu_result_e_i;
            m_store_data <= store_data_e_i;
            m_op         <= mem_op_e_i;
            m_rd         <= mem_read_e_i;
            m_wr         <= mem_write_e_i;
            m_imm        <= extended_imm_e_i;
            m_pc4        <= pc_plus4_e_i;
            m_csr        <= CSR_data_e_i;
            m_rwe        <= reg_write_en_e_i;
            m_rd_idx     <= rd_idx_e_i;
            m_src        <= result_src_e_i;
        end
    end

    always_comb begin
        is_mem = m_valid & (m_rd | m_wr);
        bad_op = (m_op == 3'b011) | (m_op[2:1] == 2'b11);
        case (m_op[1:0])
            2'b01:   bad_align = m_addr[0];
            2'b10:   bad_align = |m_addr[1:0];
            default: bad_align = 1'b0;
        endcase
        misalign  = is_mem & (bad_op | bad_align);
        mem_go    = is_mem & ~misalign;
        stall_m_o = mem_go & (state != DONE);
        tmo_last  = (tmo_cnt == CNT_W'(DMEM_TIMEOUT - 1));
    end

    // Store data replicated across every lane; strobes select the addressed bytes
    always_comb begin
        lane_wdata = m_store_data;
        lane_wstrb = 4'b1111;
        case (m_op[1:0])
            2'b00: begin
                lane_wdata = {4{m_store_data[7:0]}};
                lane_wstrb = 4'b0001 << m_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{m_store_data[15:0]}};
                lane_wstrb = 4'b0011 << {m_addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = dmem_rdata_i >> {m_addr[1:0], 3'b000};
        case (m_op)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = shifted;
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = '0;
        endcase
    end

    // Bus FSM; the timeout counter is shared by both wait states
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            m_bus_err   <= 1'b0;
            m_load_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_go) begin
                        state   <= WAIT_GNT;
                        tmo_cnt <= '0;
                    end
                end
                WAIT_GNT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (dmem_ready_i) begin
                        state   <= m_wr ? DONE : WAIT_RSP;
                        tmo_cnt <= '0;
                    end else if (tmo_last) begin
                        state     <= DONE;
                        m_bus_err <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (dmem_rvalid_i) begin
                        state       <= DONE;
                        m_load_data <= load_ext;
                    end else if (tmo_last) begin
                        state     <= DONE;
                        m_bus_err <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    m_bus_err <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dmem_req_o        = (state == WAIT_GNT);
        dmem_we_o         = dmem_req_o & m_wr;
        dmem_addr_o       = {m_addr[31:2], 2'b00};
        dmem_wdata_o      = lane_wdata;
        dmem_wstrb_o      = dmem_we_o ? lane_wstrb : 4'b0000;
        alu_result_m_o    = m_addr;
        extended_imm_m_o  = m_imm;
        pc_plus4_m_o      = m_pc4;
        CSR_data_m_o      = m_csr;
        mem_read_data_m_o = m_load_data;
        rd_idx_m_o        = m_rd_idx;
        result_src_m_o    = m_src;
        misalign_m_o      = misalign;
        bus_err_m_o       = m_bus_err;
        reg_write_en_m_o  = m_valid & m_rwe & ~stall_m_o & ~misalign & ~m_bus_err;
    end

endmodule
